alu_seq: RTL and testbench
==========================

# alu_seq

Handshaked execution unit that consumes the 3-bit ALU control code produced by the ALU control decoder, together with two operands, and returns a registered result with flags. It is the execute stage for the multi-cycle CPU. Single-cycle ops complete in one cycle. An optional iterative multiplier uses the same handshake and holds the unit busy for WIDTH cycles.

## Interface
- WIDTH, 32, operand/result width (≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at clk edge
- control  in  3  ALU op code (shared ALU_* constants)
- a, b  in  WIDTH  operands
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result when out_valid && out_ready
- result  out  WIDTH  op result
- zero  out  1  result == 0
- overflow  out  1  signed overflow (ADD/SUB only, else 0)
- illegal  out  1  control code not supported

## Operation
- Codes: ALU_AND 3'b000, ALU_OR 3'b001, ALU_ADD 3'b010, ALU_MUL 3'b011, ALU_SUB 3'b110, ALU_SLT 3'b111. All others (3'b100, 3'b101) are illegal.
- ADD/SUB: result is modulo 2^WIDTH. overflow = signed overflow.
- SLT: result = 1 if $signed(a) < $signed(b), else 0. The result is correct even when a−b overflows. overflow = 0.
- AND/OR: bitwise.
- MUL: low WIDTH bits of the unsigned a×b, computed by shift-add, one multiplier bit per cycle.
- Illegal code: result = 0, zero = 1, illegal = 1, overflow = 0. Latency is one cycle.
- FSM states:
  - IDLE: in_ready = 1.
  - MUL: busy, in_ready = 0, counter runs WIDTH→0.
  - DONE: out_valid = 1. result and flags are held stable until accepted.
- Transitions:
  - IDLE, accept of a single-cycle op → DONE.
  - IDLE, accept of MUL → MUL.
  - MUL, counter reaches 1 → DONE.
  - DONE, out_ready with no new accept → IDLE.
  - DONE, out_ready with a new accept → DONE or MUL, following the new op.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This gives back-to-back throughput of one single-cycle op per cycle.
- Operands and control are captured at accept. Later input changes have no effect.

## Timing
- Reset: state IDLE, out_valid 0, result 0, zero 0, overflow 0, illegal 0, counter 0. in_ready reads 1 while reset is held.
- Single-cycle op accepted at edge N: out_valid, result and flags are valid after edge N+1... more precisely, registered at edge N and visible in the following cycle.
- MUL accepted at edge N: out_valid rises after edge N+WIDTH, so latency is WIDTH cycles. b = 0 still takes the full WIDTH cycles.
- Back-pressure: with out_ready low, DONE holds indefinitely and in_ready = 0.
- Simultaneous output accept and input accept in DONE: the new result replaces the old one at the same edge. There is no bubble and nothing is lost.
- Reset asserted mid-MUL aborts the operation immediately. No out_valid is produced for the aborted request.

## Configuration
- ALU_SEQ_MUL_EN defined:
  - MUL state and the multiplier are present.
  - 3'b011 performs the multiply.
- ALU_SEQ_MUL_EN undefined:
  - There is no MUL state and no multiplier logic.
  - 3'b011 is treated as illegal (result 0, illegal 1, one-cycle latency).

## Structure
- Shared ALU header holds:
  - ALU_* op-code constants (3 bits), including ALU_MUL.
  - FSM state encodings (IDLE 2'd0, MUL 2'd1, DONE 2'd2).
- One sub-module, alu_mul_iter, contains the iterative shift-add engine:
  - inputs: start, a, b
  - outputs: busy, done, product
  - instantiated only under ALU_SEQ_MUL_EN.
- The FSM, single-cycle datapath and flag logic stay in alu_seq.

## Test plan
- ADD 0x7FFFFFFF + 1 → result 0x80000000, overflow 1, zero 0, out_valid one cycle after accept.
- SUB 5−5 then SLT a=0x80000000, b=1 issued back-to-back with out_ready = 1:
  - first result 0, zero 1
  - second result 1
  - in_ready stays high throughout, no bubble.
- MUL 0x0001_0003 × 0x0000_0005 → result 0x0005_000F after WIDTH cycles, in_ready 0 while busy. Without ALU_SEQ_MUL_EN the same request → illegal 1, result 0 after one cycle.
- Back-pressure: AND 0xF0F0_F0F0 & 0xFF00_FF00 with out_ready held low for 5 cycles:
  - result 0xF000_F000 held stable
  - in_ready 0
  - release → IDLE.
- Control 3'b100 → illegal 1, result 0, zero 1.
- rst_n pulsed low mid-MUL → out_valid 0, state IDLE, and a subsequent ADD 2+3 → 5 completes normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared ALU op codes, execute-stage FSM encodings and flag bundle for alu_seq.
package alu_seq_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_MUL = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic overflow;
    logic illegal;
  } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles per product.
// product/done present the final partial sum combinationally during the last iteration.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_sum;

  always_comb begin
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // A fresh start overrides any iteration in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= CW'(WIDTH);
    end else if (cnt_q != '0) begin
      acc_q    <= acc_sum;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q - CW'(1);
    end
  end

  assign busy    = (cnt_q != '0);
  assign done    = (cnt_q == CW'(1));
  assign product = acc_sum;

endmodule

// File: rtl/alu_seq.sv
// Handshaked execute stage: single-cycle ALU ops plus optional iterative multiply.
// Define ALU_SEQ_MUL_EN to build the multiplier; otherwise code 3'b011 is illegal.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  flags_t           flags_q, flags_d;
  logic             out_valid_q, out_valid_d;
  logic             fire;

  logic [WIDTH-1:0] alu_sum, alu_diff, alu_res;
  logic             alu_ovf, alu_ill;

`ifdef ALU_SEQ_MUL_EN
  logic             is_mul;
  logic             mul_start;
  logic             mul_busy, mul_done;
  logic [WIDTH-1:0] mul_product;

  assign is_mul = (control == ALU_MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign fire     = in_valid && in_ready;

  // Single-cycle datapath on the live request; only sampled on accept.
  always_comb begin
    alu_sum  = a + b;
    alu_diff = a - b;
    alu_res  = '0;
    alu_ovf  = 1'b0;
    alu_ill  = 1'b0;
    case (control)
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      ALU_ADD: begin
        alu_res = alu_sum;
        alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (alu_sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = alu_diff;
        alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (alu_diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state and output-register loads; a new accept wins over the DONE->IDLE exit.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
`ifdef ALU_SEQ_MUL_EN
    mul_start = 1'b0;
`endif
    case (state_q)
      ST_DONE: if (out_ready) state_d = ST_IDLE;
`ifdef ALU_SEQ_MUL_EN
      ST_MUL: begin
        if (mul_busy && mul_done) begin
          state_d          = ST_DONE;
          result_d         = mul_product;
          flags_d.zero     = (mul_product == '0);
          flags_d.overflow = 1'b0;
          flags_d.illegal  = 1'b0;
        end
      end
`endif
      default: ;
    endcase
    if (fire) begin
`ifdef ALU_SEQ_MUL_EN
      if (is_mul) begin
        state_d   = ST_MUL;
        mul_start = 1'b1;
      end else
`endif
      begin
        state_d          = ST_DONE;
        result_d         = alu_res;
        flags_d.zero     = (alu_res == '0);
        flags_d.overflow = alu_ovf;
        flags_d.illegal  = alu_ill;
      end
    end
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = flags_q.zero;
  assign overflow  = flags_q.overflow;
  assign illegal   = flags_q.illegal;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed requests push expected responses, a monitor
// pops and compares on every output handshake. Multiply expectations track ALU_SEQ_MUL_EN.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int unsigned WIDTH = 32;

  typedef struct packed {
    logic [31:0] res;
    logic        z;
    logic        o;
    logic        i;
  } exp_t;

  typedef struct packed {
    logic [2:0]  c;
    logic [31:0] x;
    logic [31:0] y;
    exp_t        e;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       control;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero, overflow, illegal;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .control   (control),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  function automatic exp_t mk(input logic [31:0] r, input logic z, input logic o, input logic i);
    mk = {r, z, o, i};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Compare every result the consumer actually takes.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got {res,z,o,i}=0x%0h with nothing outstanding",
                 {result, zero, overflow, illegal});
      end else begin
        mon_e = sb.pop_front();
        if ({result, zero, overflow, illegal} !== mon_e) begin
          errors++;
          $display("FAIL result: got {res,z,o,i}=0x%0h expected 0x%0h",
                   {result, zero, overflow, illegal}, mon_e);
        end
      end
    end
  end

  // Present a request from just after a rising edge; returns after the accepting edge.
  task automatic send(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                      input exp_t e, output int waited);
    control  = c;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (in_ready) begin
      sb.push_back(e);
    end else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=%0b expected 1", in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  // Scramble inputs after accept so any late sampling shows up as a wrong result.
  task automatic drop();
    in_valid = 1'b0;
    control  = 3'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic wait_valid(output int n, output int bad);
    n   = 0;
    bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (!out_valid && in_ready) bad++;
    end while (!out_valid && n < 200);
  endtask

  vec_t vecs[8];
  int   w, w2, n, bad, hold_bad, quiet;

  initial begin
    vecs[0] = '{ALU_OR,   32'h0F0F_0000, 32'h00F0_000F, mk(32'h0FFF_000F, 1'b0, 1'b0, 1'b0)};
    vecs[1] = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, mk(32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0)};
    vecs[2] = '{ALU_SLT,  32'h0000_0001, 32'h8000_0000, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0)};
    vecs[3] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0)};
    vecs[4] = '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0)};
    vecs[5] = '{3'b100,   32'h0000_0003, 32'h0000_0004, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1)};
    vecs[6] = '{3'b101,   32'h0000_FFFF, 32'h0000_0001, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1)};
    vecs[7] = '{ALU_AND,  32'h1234_5678, 32'h0000_0000, mk(32'h0000_0000, 1'b1, 1'b0, 1'b0)};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    control   = '0;
    a         = '0;
    b         = '0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result",    result,    0);
    chk("rst_zero",      zero,      0);
    chk("rst_overflow",  overflow,  0);
    chk("rst_illegal",   illegal,   0);
    chk("rst_in_ready",  in_ready,  1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Signed overflow on ADD, one-cycle latency.
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h0000_0001, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0), w);
    drop();
    wait_valid(n, bad);
    chk("add_latency", n, 1);
    @(posedge clk);
    #1;

    // Back-to-back SUB then SLT with no bubble.
    send(ALU_SUB, 32'd5, 32'd5, mk(32'h0, 1'b1, 1'b0, 1'b0), w);
    send(ALU_SLT, 32'h8000_0000, 32'h1, mk(32'h1, 1'b0, 1'b0, 1'b0), w2);
    drop();
    chk("b2b_sub_wait", w, 0);
    chk("b2b_slt_wait", w2, 0);
    @(negedge clk);
    chk("b2b_second_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Streamed table of single-cycle and illegal ops.
    foreach (vecs[k]) begin
      send(vecs[k].c, vecs[k].x, vecs[k].y, vecs[k].e, w);
      chk("stream_wait", w, 0);
    end
    drop();
    @(negedge clk);
    @(posedge clk);
    #1;

    // Multiply: WIDTH-cycle busy period, or illegal in one cycle without the multiplier.
`ifdef ALU_SEQ_MUL_EN
    send(ALU_MUL, 32'h0001_0003, 32'h0000_0005, mk(32'h0005_000F, 1'b0, 1'b0, 1'b0), w);
    drop();
    wait_valid(n, bad);
    chk("mul_latency", n, WIDTH + 1);
    chk("mul_busy_in_ready", bad, 0);
`else
    send(ALU_MUL, 32'h0001_0003, 32'h0000_0005, mk(32'h0, 1'b1, 1'b0, 1'b1), w);
    drop();
    wait_valid(n, bad);
    chk("mul_illegal_latency", n, 1);
`endif
    @(posedge clk);
    #1;

    // Back-pressure: result held stable, no new accept, then release to IDLE.
    out_ready = 1'b0;
    send(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00, mk(32'hF000_F000, 1'b0, 1'b0, 1'b0), w);
    drop();
    hold_bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== 32'hF000_F000) hold_bad++;
    end
    chk("bp_hold", hold_bad, 0);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Reset mid-multiply drops the request entirely.
    send(ALU_MUL, 32'd3, 32'd3,
`ifdef ALU_SEQ_MUL_EN
         mk(32'd9, 1'b0, 1'b0, 1'b0),
`else
         mk(32'd0, 1'b1, 1'b0, 1'b1),
`endif
         w);
    drop();
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_rst_valid", out_valid, 0);
    chk("abort_rst_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) quiet++;
    end
    chk("abort_no_valid", quiet, 0);
    @(posedge clk);
    #1;
    send(ALU_ADD, 32'd2, 32'd3, mk(32'd5, 1'b0, 1'b0, 1'b0), w);
    drop();
    wait_valid(n, bad);
    chk("post_reset_add_latency", n, 1);
    @(posedge clk);
    #1;

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
